// File: rtl/intersection_queue_sensor.sv
// Queue sensor for a two-street intersection: counts waiting vehicles,
// drains them while the street is legally green, and reports presence.

module iqs_street #(
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arrive,
   input  logic          green,
   output logic [QW-1:0] q,
   output logic [7:0]    dep,
   output logic          ovf
);

   localparam logic [QW-1:0] QMAX  = '1;
   localparam logic [3:0]    TLAST = 4'(DEPART_CYCLES - 1);

   logic [3:0] tmr;
   logic       busy;
   logic       depart;

   assign busy   = green && (q != '0);
   assign depart = busy && (tmr == TLAST);

   // Timer only runs across an unbroken green with vehicles waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr <= '0;
      end else if (!busy || depart) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         unique case (1'b1)
            (arrive && !depart): begin
               if (q == QMAX) begin
                  ovf <= 1'b1;
               end else begin
                  q <= q + 1'b1;
               end
            end
            (depart && !arrive): q <= q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dep <= '0;
      end else if (depart) begin
         dep <= dep + 8'd1;
      end
   end

endmodule

module intersection_queue_sensor #(
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arrive_a,
   input  logic          arrive_b,
   input  logic          Ra,
   input  logic          Ya,
   input  logic          Ga,
   input  logic          Rb,
   input  logic          Yb,
   input  logic          Gb,
   output logic          Ta,
   output logic          Tb,
   output logic [QW-1:0] qa,
   output logic [QW-1:0] qb,
   output logic [7:0]    dep_a,
   output logic [7:0]    dep_b,
   output logic          ovf_a,
   output logic          ovf_b,
   output logic          light_err
);

   logic onehot_a;
   logic onehot_b;
   logic conflict;
   logic illegal;
   logic green_a;
   logic green_b;

   assign onehot_a = (Ra ^ Ya ^ Ga) && !(Ra && Ya && Ga);
   assign onehot_b = (Rb ^ Yb ^ Gb) && !(Rb && Yb && Gb);
   assign conflict = (Ga || Ya) && (Gb || Yb);
   assign illegal  = !onehot_a || !onehot_b || conflict;

   // An illegal pattern blocks both greens, so neither street drains
   assign green_a = Ga && !Ra && !Ya && !illegal;
   assign green_b = Gb && !Rb && !Yb && !illegal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         light_err <= 1'b0;
      end else if (illegal) begin
         light_err <= 1'b1;
      end
   end

   iqs_street #(
      .QW            (QW),
      .DEPART_CYCLES (DEPART_CYCLES)
   ) u_street_a (
      .clk    (clk),
      .rst    (rst),
      .arrive (arrive_a),
      .green  (green_a),
      .q      (qa),
      .dep    (dep_a),
      .ovf    (ovf_a)
   );

   iqs_street #(
      .QW            (QW),
      .DEPART_CYCLES (DEPART_CYCLES)
   ) u_street_b (
      .clk    (clk),
      .rst    (rst),
      .arrive (arrive_b),
      .green  (green_b),
      .q      (qb),
      .dep    (dep_b),
      .ovf    (ovf_b)
   );

   assign Ta = (qa != '0);
   assign Tb = (qb != '0);

endmodule

// File: tb/tb_intersection_queue_sensor.sv
// Bench for intersection_queue_sensor: directed scenarios plus
// randomized traffic against a queue-level reference model.

module tb_intersection_queue_sensor;

   localparam int QW   = 4;
   localparam int DC   = 2;
   localparam int QMAX = 15;

   localparam logic [5:0] RA_GB = 6'b100_001;
   localparam logic [5:0] GA_RB = 6'b001_100;
   localparam logic [5:0] RA_RB = 6'b100_100;
   localparam logic [5:0] YA_RB = 6'b010_100;
   localparam logic [5:0] RA_YB = 6'b100_010;
   localparam logic [5:0] BOTHG = 6'b001_001;

   logic clk = 0;
   logic rst = 0;
   logic arrive_a = 0, arrive_b = 0;
   logic Ra = 1, Ya = 0, Ga = 0, Rb = 1, Yb = 0, Gb = 0;
   logic Ta, Tb;
   logic [QW-1:0] qa, qb;
   logic [7:0] dep_a, dep_b;
   logic ovf_a, ovf_b, light_err;

   int errors = 0;
   int checks = 0;

   int mq[2];
   int mst[2];
   int mdep[2];
   bit movf[2];
   bit merr;

   intersection_queue_sensor #(.QW(QW), .DEPART_CYCLES(DC)) dut (
      .clk(clk), .rst(rst),
      .arrive_a(arrive_a), .arrive_b(arrive_b),
      .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb),
      .Ta(Ta), .Tb(Tb), .qa(qa), .qb(qb),
      .dep_a(dep_a), .dep_b(dep_b),
      .ovf_a(ovf_a), .ovf_b(ovf_b), .light_err(light_err)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int s = 0; s < 2; s++) begin
         mq[s] = 0; mst[s] = 0; mdep[s] = 0; movf[s] = 0;
      end
      merr = 0;
   endtask

   // Vehicles leave after every DC-th consecutive green cycle with a queue
   task automatic model_edge();
      bit legal;
      bit grn[2];
      bit arr[2];
      bit d;
      legal = ((Ra + Ya + Ga) == 1) && ((Rb + Yb + Gb) == 1)
              && !((Ga || Ya) && (Gb || Yb));
      grn[0] = Ga && legal;
      grn[1] = Gb && legal;
      arr[0] = arrive_a;
      arr[1] = arrive_b;
      if (!legal) merr = 1;
      for (int s = 0; s < 2; s++) begin
         d = 0;
         if (grn[s] && mq[s] > 0) begin
            mst[s]++;
            if (mst[s] == DC) begin
               d = 1;
               mst[s] = 0;
            end
         end else begin
            mst[s] = 0;
         end
         if (arr[s] && !d) begin
            if (mq[s] == QMAX) movf[s] = 1;
            else mq[s]++;
         end else if (d && !arr[s]) begin
            mq[s]--;
         end
         if (d) mdep[s] = (mdep[s] + 1) % 256;
      end
   endtask

   task automatic step(input logic aa, input logic ab,
                       input logic [5:0] l);
      arrive_a = aa;
      arrive_b = ab;
      {Ra, Ya, Ga, Rb, Yb, Gb} = l;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 0;
      arrive_a = 0;
      arrive_b = 0;
      {Ra, Ya, Ga, Rb, Yb, Gb} = RA_RB;
      model_clear();
      @(posedge clk);
      #1;
      rst = 1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({qa, qb, Ta, Tb, dep_a, dep_b, ovf_a, ovf_b, light_err} !== '0) begin
         errors++;
         $display("FAIL reset_state: qa=%0d qb=%0d Ta=%b Tb=%b dep=%0d/%0d ovf=%b%b err=%b, want all 0",
                  qa, qb, Ta, Tb, dep_a, dep_b, ovf_a, ovf_b, light_err);
      end
      @(posedge clk);
      #1;
      rst = 1;
   endtask

   task automatic test_arrivals();
      apply_reset();
      step(1, 0, RA_GB);
      checks++;
      if (qa !== 4'd1 || Ta !== 1'b1) begin
         errors++;
         $display("FAIL arrive_first: qa=%0d Ta=%b, want 1 1", qa, Ta);
      end
      step(1, 0, RA_GB);
      step(1, 0, RA_GB);
      step(0, 0, RA_GB);
      checks++;
      if (qa !== 4'd3 || qb !== 4'd0 || Tb !== 1'b0) begin
         errors++;
         $display("FAIL arrive_three: qa=%0d qb=%0d Tb=%b, want 3 0 0", qa, qb, Tb);
      end
   endtask

   task automatic test_departures();
      logic [3:0] exp_q[6];
      exp_q = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 0, RA_GB);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, GA_RB);
         checks++;
         if (qa !== exp_q[i] || Ta !== (exp_q[i] != 0)) begin
            errors++;
            $display("FAIL drain_step%0d: qa=%0d Ta=%b, want %0d", i, qa, Ta, exp_q[i]);
         end
      end
      checks++;
      if (dep_a !== 8'd3 || dep_b !== 8'd0) begin
         errors++;
         $display("FAIL drain_total: dep_a=%0d dep_b=%0d, want 3 0", dep_a, dep_b);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 15; i++) step(1, 0, RA_GB);
      checks++;
      if (qa !== 4'd15 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: qa=%0d ovf_a=%b, want 15 0", qa, ovf_a);
      end
      step(1, 0, RA_GB);
      checks++;
      if (qa !== 4'd15 || ovf_a !== 1'b1 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL overflow: qa=%0d ovf_a=%b ovf_b=%b, want 15 1 0", qa, ovf_a, ovf_b);
      end
      apply_reset();
      for (int i = 0; i < 15; i++) step(1, 0, RA_GB);
      step(0, 0, GA_RB);
      step(1, 0, GA_RB);
      checks++;
      if (qa !== 4'd15 || ovf_a !== 1'b0 || dep_a !== 8'd1) begin
         errors++;
         $display("FAIL full_arrive_depart: qa=%0d ovf_a=%b dep_a=%0d, want 15 0 1",
                  qa, ovf_a, dep_a);
      end
   endtask

   task automatic test_light_err();
      apply_reset();
      step(1, 0, RA_GB);
      step(1, 0, RA_GB);
      step(0, 0, GA_RB);
      step(0, 0, BOTHG);
      checks++;
      if (light_err !== 1'b1 || qa !== 4'd2 || dep_a !== 8'd0) begin
         errors++;
         $display("FAIL illegal_cycle: err=%b qa=%0d dep_a=%0d, want 1 2 0",
                  light_err, qa, dep_a);
      end
      step(0, 0, GA_RB);
      checks++;
      if (light_err !== 1'b1 || qa !== 4'd2) begin
         errors++;
         $display("FAIL err_sticky: err=%b qa=%0d, want 1 2", light_err, qa);
      end
      step(0, 0, GA_RB);
      checks++;
      if (qa !== 4'd1 || dep_a !== 8'd1) begin
         errors++;
         $display("FAIL after_illegal: qa=%0d dep_a=%0d, want 1 1", qa, dep_a);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) step(1, 0, RA_GB);
      step(0, 0, GA_RB);
      checks++;
      if (qa !== 4'd5) begin
         errors++;
         $display("FAIL preload: qa=%0d, want 5", qa);
      end
      #3;
      arrive_a = 1;
      rst = 0;
      model_clear();
      #1;
      checks++;
      if ({qa, qb, Ta, Tb, dep_a, dep_b, ovf_a, ovf_b, light_err} !== '0) begin
         errors++;
         $display("FAIL async_reset: qa=%0d Ta=%b dep_a=%0d, want 0 0 0", qa, Ta, dep_a);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (qa !== 4'd0 || Ta !== 1'b0) begin
         errors++;
         $display("FAIL reset_ignores_arrive: qa=%0d Ta=%b, want 0 0", qa, Ta);
      end
      arrive_a = 0;
      rst = 1;
      step(1, 0, RA_GB);
      checks++;
      if (qa !== 4'd1) begin
         errors++;
         $display("FAIL resume: qa=%0d, want 1", qa);
      end
   endtask

   task automatic test_interrupted_green();
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 0, RA_GB);
      step(0, 0, GA_RB);
      step(0, 0, YA_RB);
      step(0, 0, RA_RB);
      step(0, 0, GA_RB);
      checks++;
      if (qa !== 4'd3 || dep_a !== 8'd0) begin
         errors++;
         $display("FAIL partial_dropped: qa=%0d dep_a=%0d, want 3 0", qa, dep_a);
      end
      step(0, 0, GA_RB);
      checks++;
      if (qa !== 4'd2 || dep_a !== 8'd1) begin
         errors++;
         $display("FAIL full_green_pair: qa=%0d dep_a=%0d, want 2 1", qa, dep_a);
      end
   endtask

   task automatic test_random();
      logic [5:0] l;
      int hold;
      apply_reset();
      for (int seg = 0; seg < 120; seg++) begin
         if (seg == 60) apply_reset();
         case ($urandom_range(0, 9))
            0, 1, 2, 3: l = GA_RB;
            4, 5:       l = RA_GB;
            6:          l = YA_RB;
            7:          l = RA_YB;
            8:          l = RA_RB;
            default:    l = 6'($urandom);
         endcase
         hold = $urandom_range(1, 7);
         for (int c = 0; c < hold; c++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), l);
            checks++;
            if (qa !== 4'(mq[0]) || qb !== 4'(mq[1])
                || Ta !== (mq[0] != 0) || Tb !== (mq[1] != 0)
                || dep_a !== 8'(mdep[0]) || dep_b !== 8'(mdep[1])
                || ovf_a !== movf[0] || ovf_b !== movf[1]
                || light_err !== merr) begin
               errors++;
               $display("FAIL random seg%0d: q=%0d/%0d T=%b%b dep=%0d/%0d ovf=%b%b err=%b, want q=%0d/%0d dep=%0d/%0d ovf=%b%b err=%b",
                        seg, qa, qb, Ta, Tb, dep_a, dep_b, ovf_a, ovf_b, light_err,
                        mq[0], mq[1], mdep[0], mdep[1], movf[0], movf[1], merr);
            end
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_arrivals();
      test_departures();
      test_overflow();
      test_light_err();
      test_async_reset();
      test_interrupted_green();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/intersection_queue_sensor.md
INTERSECTION_QUEUE_SENSOR -- requirements
Module: intersection_queue_sensor

Interface
REQ-001 SHALL have parameter QW, default 4, meaning width of each street's vehicle-queue count.
REQ-002 SHALL have parameter DEPART_CYCLES, default 2, meaning green cycles needed per vehicle departure (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports arrive_a, arrive_b  input  1 each  one-cycle vehicle-arrival strobe for street A or B.
REQ-006 SHALL have ports Ra, Ya, Ga, Rb, Yb, Gb  input  1 each  light outputs from the traffic-light controller.
REQ-007 SHALL have ports Ta, Tb  output  1 each  traffic-present sensor outputs to the controller.
REQ-008 SHALL have ports qa, qb  output  QW each  current queue count per street.
REQ-009 SHALL have ports dep_a, dep_b  output  8 each  wrapping departure totals per street.
REQ-010 SHALL have ports ovf_a, ovf_b  output  1 each  sticky queue-overflow flags.
REQ-011 SHALL have port light_err  output  1  sticky illegal-light-pattern flag.

Function
REQ-012 SHALL treat street X as GREEN only when Gx=1, Rx=0, Yx=0, and the cycle is legal per REQ-013.
REQ-013 SHALL flag a cycle illegal when either street's {R,Y,G} is not one-hot, or when (Ga|Ya) and (Gb|Yb) are both 1.
REQ-014 SHALL set light_err on the rising edge following any illegal cycle and hold it until reset.
REQ-015 SHALL keep a per-street departure timer, 4 bits, that increments each cycle the street is GREEN with qx>0.
REQ-016 SHALL clear the timer to 0 on any cycle the street is not GREEN or qx=0; a partial count is never carried into the next green.
REQ-017 SHALL assert an internal depart for a street when GREEN, qx>0 and timer=DEPART_CYCLES-1, then reset the timer to 0 in the same edge.
REQ-018 SHALL limit departures to one per DEPART_CYCLES consecutive green cycles; with DEPART_CYCLES=1, one per green cycle.
REQ-019 SHALL update qx = qx + arrive_x - depart_x each edge; simultaneous arrive and depart leave qx unchanged.
REQ-020 SHALL saturate qx at 2^QW-1 when arrive without depart occurs at full count, and set ovf_x, sticky until reset.
REQ-021 SHALL never decrement qx below 0; depart is impossible at qx=0.
REQ-022 SHALL increment dep_x by 1 per departure, modulo 256 (255 -> 0).
REQ-023 SHALL drive Tx = (qx != 0) from the registered count, so Tx rises one edge after the first arrival and falls on the edge where the last vehicle departs.
REQ-024 SHALL process streets A and B independently apart from the shared legality check.
REQ-025 SHALL suppress departures on both streets during illegal cycles, while still accepting arrivals.

Reset
REQ-026 SHALL on rst=0 immediately force qa=qb=0, Ta=Tb=0, dep_a=dep_b=0, ovf_a=ovf_b=0, light_err=0 and both timers to 0, regardless of clk.
REQ-027 SHALL resume counting on the first rising edge after rst returns to 1; arrivals while rst=0 are discarded.

Verification
REQ-028 SHALL pass: Ra=1, Gb=1, arrive_a pulsed on 3 edges -> qa=3, Ta=1 after first edge; qb=0, Tb=0.
REQ-029 SHALL pass: qa=3, Ga=1, Rb=1, DEPART_CYCLES=2, 6 green cycles -> qa steps 3,3,2,2,1,1,0, Ta falls with qa=0, dep_a=3.
REQ-030 SHALL pass: qa=15 (QW=4), arrive_a with Ra=1 -> qa stays 15, ovf_a=1; arrive_a together with a depart at qa=15 -> qa stays 15, no new overflow.
REQ-031 SHALL pass: Ga=1 and Gb=1 for one cycle -> light_err=1 next edge, no departures that cycle, and light_err remains 1 after lights become legal.
REQ-032 SHALL pass: rst driven low mid-green between clock edges with qa=5 -> all outputs 0 immediately; arrive_a during reset ignored.
REQ-033 SHALL pass: green removed at timer=1 (DEPART_CYCLES=2) then restored -> next departure only after 2 full green cycles.
